// File: rtl/systolic_tile_sequencer.sv
// rtl/systolic_tile_sequencer.sv - sequences one output tile of an ARRAY_N x ARRAY_N systolic MAC array
// Optional feature macro: SEQ_ABORT_EN (adds abort input that discards the tile in progress).
module systolic_tile_sequencer #(
    parameter int ARRAY_N = 4,
    parameter int K_W     = 8,
    parameter int ADDR_W  = 10
) (
    input  logic               clk,
    input  logic               reset,
`ifdef SEQ_ABORT_EN
    input  logic               abort,
`endif
    input  logic               start,
    input  logic [K_W-1:0]     k_len,
    input  logic [ADDR_W-1:0]  a_base,
    input  logic [ADDR_W-1:0]  b_base,
    output logic               busy,
    output logic               done,
    output logic               a_rd_en,
    output logic               b_rd_en,
    output logic [ADDR_W-1:0]  a_addr,
    output logic [ADDR_W-1:0]  b_addr,
    output logic               pe_clr,
    output logic [ARRAY_N-1:0] row_valid,
    output logic [ARRAY_N-1:0] col_valid,
    output logic               capture
);
    localparam int DR_W = $clog2(2 * ARRAY_N);
    localparam logic [DR_W-1:0] DRAIN_LAST = DR_W'(2 * ARRAY_N - 1);

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, CAPTURE, DONE} state_t;

    state_t              state_q, state_d;
    logic [K_W-1:0]      k_m1_q, k_m1_d;
    logic [K_W-1:0]      feed_cnt_q, feed_cnt_d;
    logic [DR_W-1:0]     drain_cnt_q, drain_cnt_d;
    logic [ADDR_W-1:0]   a_base_q, a_base_d, b_base_q, b_base_d;
    logic [ADDR_W-1:0]   a_addr_q, a_addr_d, b_addr_q, b_addr_d;
    logic                a_rd_q, a_rd_d, b_rd_q, b_rd_d;
    logic                busy_q, busy_d, done_q, done_d;
    logic                pe_clr_q, pe_clr_d, capture_q, capture_d;
    logic [ARRAY_N-1:0]  row_q, row_d, col_q, col_d;
    logic                flush;

    always_comb begin
        state_d     = state_q;
        k_m1_d      = k_m1_q;
        feed_cnt_d  = feed_cnt_q;
        drain_cnt_d = drain_cnt_q;
        a_base_d    = a_base_q;
        b_base_d    = b_base_q;
        flush       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (k_len != '0) begin
                        state_d  = CLEAR;
                        k_m1_d   = k_len - K_W'(1);
                        a_base_d = a_base;
                        b_base_d = b_base;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            CLEAR: begin
                state_d    = FEED;
                feed_cnt_d = '0;
            end
            FEED: begin
                // Compare against k_len-1 so a full-scale k_len never overflows the counter.
                if (feed_cnt_q == k_m1_q) begin
                    state_d     = DRAIN;
                    drain_cnt_d = '0;
                end else begin
                    feed_cnt_d = feed_cnt_q + K_W'(1);
                end
            end
            DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) state_d = CAPTURE;
                else drain_cnt_d = drain_cnt_q + DR_W'(1);
            end
            CAPTURE: state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

`ifdef SEQ_ABORT_EN
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            flush   = 1'b1;
        end
`endif

        busy_d    = (state_d != IDLE);
        pe_clr_d  = (state_d == CLEAR) || flush;
        a_rd_d    = (state_d == FEED);
        b_rd_d    = (state_d == FEED);
        capture_d = (state_d == CAPTURE);
        done_d    = (state_d == DONE);

        a_addr_d = a_addr_q;
        b_addr_d = b_addr_q;
        if (state_d == FEED) begin
            a_addr_d = (state_q == CLEAR) ? a_base_q : a_addr_q + ADDR_W'(1);
            b_addr_d = (state_q == CLEAR) ? b_base_q : b_addr_q + ADDR_W'(1);
        end

        // Lane r sees read data 1+r cycles after the read; pipes drain to zero during DRAIN.
        row_d = flush ? '0 : {row_q[ARRAY_N-2:0], a_rd_q};
        col_d = flush ? '0 : {col_q[ARRAY_N-2:0], b_rd_q};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            k_m1_q      <= '0;
            feed_cnt_q  <= '0;
            drain_cnt_q <= '0;
            a_base_q    <= '0;
            b_base_q    <= '0;
            a_addr_q    <= '0;
            b_addr_q    <= '0;
            a_rd_q      <= 1'b0;
            b_rd_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pe_clr_q    <= 1'b0;
            capture_q   <= 1'b0;
            row_q       <= '0;
            col_q       <= '0;
        end else begin
            state_q     <= state_d;
            k_m1_q      <= k_m1_d;
            feed_cnt_q  <= feed_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            a_base_q    <= a_base_d;
            b_base_q    <= b_base_d;
            a_addr_q    <= a_addr_d;
            b_addr_q    <= b_addr_d;
            a_rd_q      <= a_rd_d;
            b_rd_q      <= b_rd_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pe_clr_q    <= pe_clr_d;
            capture_q   <= capture_d;
            row_q       <= row_d;
            col_q       <= col_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign a_rd_en   = a_rd_q;
    assign b_rd_en   = b_rd_q;
    assign a_addr    = a_addr_q;
    assign b_addr    = b_addr_q;
    assign pe_clr    = pe_clr_q;
    assign capture   = capture_q;
    assign row_valid = row_q;
    assign col_valid = col_q;
endmodule
